// File: rtl/scm65_arb.sv
// scm65_arb: two-client arbiter and sequencer for the scm65 memory.
// Round-robin arbitration on the write and read ports, read-after-write
// hazard blocking, and an RD_LAT-deep return pipeline that routes DOUT
// back to the client that issued the read.
module scm65_arb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  // scm65 read latency in cycles; legal values are 1 to 3
  parameter int RD_LAT     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  C0_WREQ,
  input  logic [ADDR_WIDTH-1:0] C0_WADDR,
  input  logic [DATA_WIDTH-1:0] C0_DIN,
  output logic                  C0_WGNT,
  input  logic                  C1_WREQ,
  input  logic [ADDR_WIDTH-1:0] C1_WADDR,
  input  logic [DATA_WIDTH-1:0] C1_DIN,
  output logic                  C1_WGNT,

  input  logic                  C0_RREQ,
  input  logic [ADDR_WIDTH-1:0] C0_RADDR,
  output logic                  C0_RGNT,
  output logic                  C0_RVALID,
  input  logic                  C1_RREQ,
  input  logic [ADDR_WIDTH-1:0] C1_RADDR,
  output logic                  C1_RGNT,
  output logic                  C1_RVALID,

  output logic [DATA_WIDTH-1:0] RDATA,

  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] WADDR,
  output logic [DATA_WIDTH-1:0] DIN,

  output logic                  RE,
  output logic [ADDR_WIDTH-1:0] RADDR,
  input  logic [DATA_WIDTH-1:0] DOUT
);

  // Round-robin pointers name the client that wins a contested cycle.
  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_t;

  client_t r_wPtr;
  client_t r_rPtr;

  // Return pipeline: one valid bit and one client id bit per stage.
  logic [RD_LAT-1:0] r_pipeValid;
  logic [RD_LAT-1:0] r_pipeId;

  logic                  w_wGnt0;
  logic                  w_wGnt1;
  logic                  w_rWin0;
  logic                  w_rWin1;
  logic                  w_hazard;
  logic                  w_rGnt0;
  logic                  w_rGnt1;
  logic [ADDR_WIDTH-1:0] w_wAddr;
  logic [DATA_WIDTH-1:0] w_din;
  logic [ADDR_WIDTH-1:0] w_rWinAddr;
  logic [ADDR_WIDTH-1:0] w_rAddr;

  // Write arbitration: a lone requester wins, a contested cycle goes to wptr.
  // Grants are forced low while reset is held.
  always_comb begin
    w_wGnt0 = 1'b0;
    w_wGnt1 = 1'b0;
    w_wAddr = '0;
    w_din   = '0;
    if (!RST) begin
      w_wGnt0 = C0_WREQ & (~C1_WREQ | (r_wPtr == CLIENT0));
      w_wGnt1 = C1_WREQ & (~C0_WREQ | (r_wPtr == CLIENT1));
    end
    if (w_wGnt0) begin
      w_wAddr = C0_WADDR;
      w_din   = C0_DIN;
    end else if (w_wGnt1) begin
      w_wAddr = C1_WADDR;
      w_din   = C1_DIN;
    end
  end

  // Read arbitration picks a winner, then withholds its grant when the winner
  // targets the row being written this cycle; the write always goes ahead.
  always_comb begin
    w_rWin0    = 1'b0;
    w_rWin1    = 1'b0;
    w_rWinAddr = '0;
    w_hazard   = 1'b0;
    w_rGnt0    = 1'b0;
    w_rGnt1    = 1'b0;
    w_rAddr    = '0;
    if (!RST) begin
      w_rWin0 = C0_RREQ & (~C1_RREQ | (r_rPtr == CLIENT0));
      w_rWin1 = C1_RREQ & (~C0_RREQ | (r_rPtr == CLIENT1));
    end
    w_rWinAddr = w_rWin1 ? C1_RADDR : C0_RADDR;
    w_hazard   = (w_wGnt0 | w_wGnt1) & (w_rWin0 | w_rWin1) & (w_rWinAddr == w_wAddr);
    w_rGnt0    = w_rWin0 & ~w_hazard;
    w_rGnt1    = w_rWin1 & ~w_hazard;
    if (w_rGnt0) begin
      w_rAddr = C0_RADDR;
    end else if (w_rGnt1) begin
      w_rAddr = C1_RADDR;
    end
  end

  // After a granted transfer the pointer hands priority to the other client;
  // a hazard-blocked read leaves rptr where it was.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wPtr <= CLIENT0;
      r_rPtr <= CLIENT0;
    end else begin
      if (w_wGnt0) begin
        r_wPtr <= CLIENT1;
      end else if (w_wGnt1) begin
        r_wPtr <= CLIENT0;
      end
      if (w_rGnt0) begin
        r_rPtr <= CLIENT1;
      end else if (w_rGnt1) begin
        r_rPtr <= CLIENT0;
      end
    end
  end

  // Each granted read enters the pipeline and emerges RD_LAT cycles later,
  // lined up with DOUT; reset drops every read still in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pipeValid <= '0;
      r_pipeId    <= '0;
    end else begin
      r_pipeValid[0] <= w_rGnt0 | w_rGnt1;
      r_pipeId[0]    <= w_rGnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeId[i]    <= r_pipeId[i-1];
      end
    end
  end

  assign C0_WGNT   = w_wGnt0;
  assign C1_WGNT   = w_wGnt1;
  assign C0_RGNT   = w_rGnt0;
  assign C1_RGNT   = w_rGnt1;

  assign WE        = w_wGnt0 | w_wGnt1;
  assign WADDR     = w_wAddr;
  assign DIN       = w_din;
  assign RE        = w_rGnt0 | w_rGnt1;
  assign RADDR     = w_rAddr;

  assign C0_RVALID = r_pipeValid[RD_LAT-1] & ~r_pipeId[RD_LAT-1];
  assign C1_RVALID = r_pipeValid[RD_LAT-1] &  r_pipeId[RD_LAT-1];
  assign RDATA     = DOUT;

endmodule

// File: tb/tb_scm65_arb.sv
// tb_scm65_arb: self-checking bench for scm65_arb with a behavioural scm65
// memory, a scoreboard that predicts grants and returns, and random traffic.
module tb_scm65_arb;

  localparam int AW       = 6;
  localparam int DW       = 64;
  localparam int LAT      = 1;
  localparam int ROWS     = 1 << AW;
  localparam int WAIT_MAX = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          C0_WREQ, C1_WREQ, C0_RREQ, C1_RREQ;
  logic [AW-1:0] C0_WADDR, C1_WADDR, C0_RADDR, C1_RADDR;
  logic [DW-1:0] C0_DIN, C1_DIN;
  logic          C0_WGNT, C1_WGNT, C0_RGNT, C1_RGNT, C0_RVALID, C1_RVALID;
  logic [DW-1:0] RDATA, DIN, DOUT;
  logic          WE, RE;
  logic [AW-1:0] WADDR, RADDR;

  scm65_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .C0_WREQ(C0_WREQ), .C0_WADDR(C0_WADDR), .C0_DIN(C0_DIN), .C0_WGNT(C0_WGNT),
    .C1_WREQ(C1_WREQ), .C1_WADDR(C1_WADDR), .C1_DIN(C1_DIN), .C1_WGNT(C1_WGNT),
    .C0_RREQ(C0_RREQ), .C0_RADDR(C0_RADDR), .C0_RGNT(C0_RGNT), .C0_RVALID(C0_RVALID),
    .C1_RREQ(C1_RREQ), .C1_RADDR(C1_RADDR), .C1_RGNT(C1_RGNT), .C1_RVALID(C1_RVALID),
    .RDATA(RDATA), .WE(WE), .WADDR(WADDR), .DIN(DIN),
    .RE(RE), .RADDR(RADDR), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural scm65: write and read sampled on the same edge, read data
  // appears LAT cycles after the sampling edge.
  logic [DW-1:0] memArr [ROWS];
  logic [DW-1:0] doutPipe [LAT];
  always @(posedge CLK) begin
    if (WE) memArr[WADDR] <= DIN;
    if (RE) doutPipe[0] <= memArr[RADDR];
    for (int i = 1; i < LAT; i++) doutPipe[i] <= doutPipe[i-1];
  end
  assign DOUT = doutPipe[LAT-1];

  // Client request state, held until the scoreboard sees the grant.
  logic          cwReq [2];
  logic [AW-1:0] cwAddr [2];
  logic [DW-1:0] cwDat [2];
  logic          crReq [2];
  logic [AW-1:0] crAddr [2];
  int            wWait [2];
  int            rWait [2];
  bit            randomOn = 1'b0;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus();
    C0_WREQ = cwReq[0]; C0_WADDR = cwAddr[0]; C0_DIN = cwDat[0];
    C1_WREQ = cwReq[1]; C1_WADDR = cwAddr[1]; C1_DIN = cwDat[1];
    C0_RREQ = crReq[0]; C0_RADDR = crAddr[0];
    C1_RREQ = crReq[1]; C1_RADDR = crAddr[1];
  endtask

  // Reference model: row contents, last winner on each port, pending returns.
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } ret_t;

  logic [DW-1:0] refMem [ROWS];
  ret_t          retQ [$];
  int            lastWriter = 1;
  int            lastReader = 1;
  int            cyc = 0;
  int            sWWin = -1;
  int            sRWin = -1;
  logic [AW-1:0] sWAddr, sRAddr;
  logic [DW-1:0] sDin;
  bit            gW [2];
  bit            gR [2];

  // Predict and compare every cycle, away from the rising edge.
  always @(negedge CLK) begin
    int            wCand;
    int            rCand;
    logic          expV0, expV1;
    logic [DW-1:0] expData;
    logic [AW-1:0] expWAddr, expRAddr;
    logic [DW-1:0] expDin;
    wCand = -1;
    rCand = -1;
    if (RST) begin
      lastWriter = 1;
      lastReader = 1;
      retQ.delete();
    end else begin
      if (cwReq[0] && cwReq[1]) wCand = 1 - lastWriter;
      else if (cwReq[0]) wCand = 0;
      else if (cwReq[1]) wCand = 1;
      if (crReq[0] && crReq[1]) rCand = 1 - lastReader;
      else if (crReq[0]) rCand = 0;
      else if (crReq[1]) rCand = 1;
      if (wCand >= 0 && rCand >= 0 && crAddr[rCand] == cwAddr[wCand]) rCand = -1;
    end
    expWAddr = (wCand >= 0) ? cwAddr[wCand] : '0;
    expDin   = (wCand >= 0) ? cwDat[wCand] : '0;
    expRAddr = (rCand >= 0) ? crAddr[rCand] : '0;
    checkOutput("C0_WGNT", C0_WGNT, wCand == 0);
    checkOutput("C1_WGNT", C1_WGNT, wCand == 1);
    checkOutput("C0_RGNT", C0_RGNT, rCand == 0);
    checkOutput("C1_RGNT", C1_RGNT, rCand == 1);
    checkOutput("WE", WE, wCand >= 0);
    checkOutput("RE", RE, rCand >= 0);
    checkOutput("WADDR", WADDR, expWAddr);
    checkOutput("DIN", DIN, expDin);
    checkOutput("RADDR", RADDR, expRAddr);
    expV0 = 1'b0;
    expV1 = 1'b0;
    expData = '0;
    if (retQ.size() > 0 && retQ[0].due == cyc) begin
      if (retQ[0].id == 0) expV0 = 1'b1; else expV1 = 1'b1;
      expData = retQ[0].data;
      void'(retQ.pop_front());
    end
    checkOutput("C0_RVALID", C0_RVALID, expV0);
    checkOutput("C1_RVALID", C1_RVALID, expV1);
    if (expV0 || expV1) checkOutput("RDATA", RDATA, expData);
    sWWin = wCand;
    sRWin = rCand;
    sWAddr = expWAddr;
    sDin = expDin;
    sRAddr = expRAddr;
  end

  // Commit the transfers that happened at this edge into the model.
  always @(posedge CLK) begin
    ret_t e;
    #1;
    gW[0] = (sWWin == 0); gW[1] = (sWWin == 1);
    gR[0] = (sRWin == 0); gR[1] = (sRWin == 1);
    if (sRWin >= 0) begin
      e.id = sRWin;
      e.data = refMem[sRAddr];
      e.due = cyc + LAT;
      retQ.push_back(e);
      lastReader = sRWin;
    end
    if (sWWin >= 0) begin
      refMem[sWAddr] = sDin;
      lastWriter = sWWin;
    end
    sWWin = -1;
    sRWin = -1;
    cyc++;
  end

  // Client behaviour: drop a granted request, track waiting, and create new
  // random requests when traffic is enabled.
  always @(posedge CLK) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (gW[i]) begin
        checkOutput("wWait", wWait[i] <= WAIT_MAX, 1);
        cwReq[i] = 1'b0;
        wWait[i] = 0;
      end else if (cwReq[i]) wWait[i]++;
      if (gR[i]) begin
        checkOutput("rWait", rWait[i] <= WAIT_MAX, 1);
        crReq[i] = 1'b0;
        rWait[i] = 0;
      end else if (crReq[i]) rWait[i]++;
      if (randomOn && !RST && !cwReq[i] && $urandom_range(99) < 50) begin
        cwReq[i] = 1'b1;
        cwAddr[i] = AW'($urandom_range(ROWS-1));
        cwDat[i] = {$urandom, $urandom};
      end
      if (randomOn && !RST && !crReq[i] && $urandom_range(99) < 50) begin
        crReq[i] = 1'b1;
        crAddr[i] = AW'($urandom_range(ROWS-1));
      end
    end
    applyStimulus();
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while ((cwReq[0] || cwReq[1] || crReq[0] || crReq[1]) && n < 20) begin
      @(posedge CLK); #3;
      n++;
    end
    if (n >= 20) checkOutput("idleTimeout", 64'(n), 64'd0);
  endtask

  task automatic clearClients();
    for (int i = 0; i < 2; i++) begin
      cwReq[i] = 1'b0; crReq[i] = 1'b0;
      wWait[i] = 0; rWait[i] = 0;
    end
    applyStimulus();
  endtask

  task automatic doWrite(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge CLK); #3;
    cwReq[c] = 1'b1; cwAddr[c] = a; cwDat[c] = d;
    applyStimulus();
    waitIdle();
  endtask

  initial begin
    logic [DW-1:0] rowA, rowB;
    for (int r = 0; r < ROWS; r++) begin
      memArr[r] = '0;
      refMem[r] = '0;
    end
    for (int i = 0; i < LAT; i++) doutPipe[i] = '0;
    for (int i = 0; i < 2; i++) begin
      cwAddr[i] = '0; cwDat[i] = '0; crAddr[i] = '0;
      gW[i] = 1'b0; gR[i] = 1'b0;
    end
    // Requests presented during reset must see no grants.
    cwReq[0] = 1'b1; cwReq[1] = 1'b1; crReq[0] = 1'b1; crReq[1] = 1'b1;
    wWait[0] = 0; wWait[1] = 0; rWait[0] = 0; rWait[1] = 0;
    applyStimulus();
    #1;
    checkOutput("rstWgnt", {C0_WGNT, C1_WGNT}, 2'b00);
    checkOutput("rstRgnt", {C0_RGNT, C1_RGNT}, 2'b00);
    checkOutput("rstWeRe", {WE, RE}, 2'b00);
    checkOutput("rstRvalid", {C0_RVALID, C1_RVALID}, 2'b00);
    @(posedge CLK); #3;
    clearClients();
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;

    // Write fairness: both clients keep a write pending for six cycles.
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #3;
      for (int i = 0; i < 2; i++) begin
        if (!cwReq[i]) begin
          cwReq[i] = 1'b1;
          cwAddr[i] = AW'(10 + 2 * k + i);
          cwDat[i] = {32'hFA12_0000, 16'(k), 16'(i)};
        end
      end
      applyStimulus();
      @(negedge CLK);
      checkOutput("fairC0", C0_WGNT, (k % 2) == 0);
      checkOutput("fairC1", C1_WGNT, (k % 2) == 1);
      checkOutput("fairWaddr", WADDR, cwAddr[k % 2]);
      checkOutput("fairDin", DIN, cwDat[k % 2]);
    end
    @(posedge CLK); #3;
    waitIdle();

    // Basic write then read of row 5.
    @(posedge CLK); #3;
    cwReq[0] = 1'b1; cwAddr[0] = 6'd5; cwDat[0] = 64'hDEADBEEF_00000005;
    applyStimulus();
    @(negedge CLK);
    checkOutput("basicWgnt", C0_WGNT, 1);
    @(posedge CLK); #3;
    crReq[1] = 1'b1; crAddr[1] = 6'd5;
    applyStimulus();
    @(negedge CLK);
    checkOutput("basicRgnt", C1_RGNT, 1);
    @(negedge CLK);
    checkOutput("basicRvalid1", C1_RVALID, 1);
    checkOutput("basicRvalid0", C0_RVALID, 0);
    checkOutput("basicRdata", RDATA, 64'hDEADBEEF_00000005);
    @(posedge CLK); #3;
    waitIdle();

    // Read-after-write hazard on row 9.
    rowA = 64'hA5A5_0009_5A5A_1234;
    @(posedge CLK); #3;
    cwReq[0] = 1'b1; cwAddr[0] = 6'd9; cwDat[0] = rowA;
    crReq[1] = 1'b1; crAddr[1] = 6'd9;
    applyStimulus();
    @(negedge CLK);
    checkOutput("hzWgnt", C0_WGNT, 1);
    checkOutput("hzRgnt", C1_RGNT, 0);
    checkOutput("hzRe", RE, 0);
    @(negedge CLK);
    checkOutput("hzRgntNext", C1_RGNT, 1);
    @(negedge CLK);
    checkOutput("hzRvalid", C1_RVALID, 1);
    checkOutput("hzRdata", RDATA, rowA);
    @(posedge CLK); #3;
    waitIdle();

    // Concurrent read of row 3 by C0 and write of row 7 by C1.
    rowB = 64'h0000_0003_C0DE_0003;
    doWrite(0, 6'd3, rowB);
    @(posedge CLK); #3;
    crReq[0] = 1'b1; crAddr[0] = 6'd3;
    cwReq[1] = 1'b1; cwAddr[1] = 6'd7; cwDat[1] = 64'h7777_0007_1111_0007;
    applyStimulus();
    @(negedge CLK);
    checkOutput("concRgnt", C0_RGNT, 1);
    checkOutput("concWgnt", C1_WGNT, 1);
    @(negedge CLK);
    checkOutput("concRvalid", C0_RVALID, 1);
    checkOutput("concRdata", RDATA, rowB);
    @(posedge CLK); #3;
    waitIdle();

    // Fill every row, alternating clients.
    for (int r = 0; r < ROWS; r++) doWrite(r % 2, AW'(r), {$urandom, $urandom});

    // Reset asserted in the middle of random traffic.
    randomOn = 1'b1;
    repeat (20 + $urandom_range(15)) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    checkOutput("midRstWgnt", {C0_WGNT, C1_WGNT}, 2'b00);
    checkOutput("midRstRgnt", {C0_RGNT, C1_RGNT}, 2'b00);
    checkOutput("midRstWeRe", {WE, RE}, 2'b00);
    checkOutput("midRstRvalid", {C0_RVALID, C1_RVALID}, 2'b00);
    randomOn = 1'b0;
    @(posedge CLK); #3;
    clearClients();
    @(posedge CLK); #3;
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checkOutput("postRstRvalid", {C0_RVALID, C1_RVALID}, 2'b00);
    end
    @(posedge CLK); #3;
    cwReq[0] = 1'b1; cwAddr[0] = 6'd40; cwDat[0] = 64'h40;
    cwReq[1] = 1'b1; cwAddr[1] = 6'd41; cwDat[1] = 64'h41;
    applyStimulus();
    @(negedge CLK);
    checkOutput("postRstC0", C0_WGNT, 1);
    checkOutput("postRstC1", C1_WGNT, 0);
    @(posedge CLK); #3;
    waitIdle();

    // Random soak against the reference model.
    randomOn = 1'b1;
    repeat (1000) @(posedge CLK);
    randomOn = 1'b0;
    #3;
    waitIdle();
    repeat (LAT + 3) @(posedge CLK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
